// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared widths, reset PC, buffer entry type and sizing helpers for the fetch unit
package ifu_pkg;

  localparam int         IFU_ADDR_W   = 8;
  localparam int         IFU_DATA_W   = 8;
  localparam logic [7:0] IFU_RESET_PC = 8'h00;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] data;
    logic [IFU_ADDR_W-1:0] pc;
  } ifu_entry_t;

  // Counter must reach DEPTH itself, so it needs one more code than the pointer.
  function automatic int ifu_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ifu_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO with flush; head word is read straight from the storage flops
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output logic [WIDTH-1:0]            head_data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [ifu_cnt_w(DEPTH)-1:0] count_o
);

  localparam int PW = ifu_ptr_w(DEPTH);
  localparam int CW = ifu_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CW'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign do_pop      = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, ROM fetch issue/capture and instruction buffer; IFU_PREFETCH_EN selects a FIFO_DEPTH prefetch buffer
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = IFU_ADDR_W,
  parameter int                DATA_W     = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = IFU_RESET_PC,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr_program,
  input  logic [DATA_W-1:0] data_program,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = ifu_cnt_w(DEPTH);
  localparam int OW = CW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              inflight_q, inflight_d;
  logic              pop, push, issue, fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [OW-1:0]     occupancy;
  logic [DATA_W+ADDR_W-1:0] head;

  // The in-flight word's capture slot is the redirect cycle itself, so gating
  // push with redirect is all the squash that is needed.
  assign pop       = ins_valid & ins_ready;
  assign push      = inflight_q & ~redirect & ~fifo_full;
  assign occupancy = OW'(fifo_count) - OW'(pop) + OW'(inflight_q);
  assign issue     = ~halt & ~redirect & (occupancy < OW'(DEPTH));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      inflight_d = 1'b1;
      tag_d      = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({data_program, tag_q}),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_data_o (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign addr_program = fetch_pc_q;
  assign ins_valid    = ~fifo_empty;
  assign ins_data     = head[DATA_W+ADDR_W-1:ADDR_W];
  assign ins_pc       = head[ADDR_W-1:0];

endmodule
